// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb
// Brief    : Round-robin arbiter sharing one combinational ALU between NREQ
//            requesters, with a registered issue stage and per-requester
//            response slots.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arb #(
    parameter int NREQ = 2
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [5*NREQ-1:0]    req_op_i,
    input  logic [32*NREQ-1:0]   req_a_i,
    input  logic [32*NREQ-1:0]   req_b_i,
    output logic [4:0]           alu_op_o,
    output logic [31:0]          alu_a_o,
    output logic [31:0]          alu_b_o,
    input  logic [31:0]          alu_result_i,
    input  logic                 alu_flag_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic [32*NREQ-1:0]   rsp_result_o,
    output logic [NREQ-1:0]      rsp_flag_o
);

    localparam int              C_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [C_PTR_W-1:0] C_LAST = C_PTR_W'(NREQ - 1);
    localparam logic [C_PTR_W:0]   C_NREQ = (C_PTR_W + 1)'(NREQ);

    logic [NREQ-1:0]      r_busy;
    logic                 r_iss_valid;
    logic [C_PTR_W-1:0]   r_iss_id;
    logic [4:0]           r_iss_op;
    logic [31:0]          r_iss_a;
    logic [31:0]          r_iss_b;
    logic [NREQ-1:0]      r_rsp_valid;
    logic [31:0]          r_rsp_result [NREQ];
    logic [NREQ-1:0]      r_rsp_flag;
    logic [C_PTR_W-1:0]   r_rr_ptr;

    logic [NREQ-1:0]      w_eligible;
    logic [NREQ-1:0]      w_rot;
    logic [C_PTR_W-1:0]   w_off;
    logic [C_PTR_W:0]     w_sum;
    logic                 w_gnt_valid;
    logic [C_PTR_W-1:0]   w_gnt_id;
    logic [C_PTR_W-1:0]   w_rr_next;
    logic [4:0]           w_sel_op;
    logic [31:0]          w_sel_a;
    logic [31:0]          w_sel_b;

    assign w_eligible = req_valid_i & ~r_busy;

    // Rotate the eligible vector so bit 0 is the requester at r_rr_ptr; the
    // lowest set bit is then the round-robin winner.
    assign w_rot = NREQ'({w_eligible, w_eligible} >> r_rr_ptr);

    always_comb begin
        w_gnt_valid = 1'b0;
        w_off       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_gnt_valid = 1'b1;
                w_off       = C_PTR_W'(k);
            end
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        if (w_sum >= C_NREQ) begin
            w_sum = w_sum - C_NREQ;
        end
        w_gnt_id  = w_sum[C_PTR_W-1:0];
        w_rr_next = (w_gnt_id == C_LAST) ? '0 : w_gnt_id + C_PTR_W'(1);
    end

    always_comb begin
        req_ready_o = '0;
        w_sel_op    = '0;
        w_sel_a     = '0;
        w_sel_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_id == C_PTR_W'(i)) begin
                req_ready_o[i] = rstn_i & w_gnt_valid;
                w_sel_op       = req_op_i[5*i +: 5];
                w_sel_a        = req_a_i[32*i +: 32];
                w_sel_b        = req_b_i[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_busy      <= '0;
            r_iss_valid <= 1'b0;
            r_iss_id    <= '0;
            r_iss_op    <= '0;
            r_iss_a     <= '0;
            r_iss_b     <= '0;
            r_rsp_valid <= '0;
            r_rsp_flag  <= '0;
            r_rr_ptr    <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_rsp_result[i] <= '0;
            end
        end else begin
            r_iss_valid <= w_gnt_valid;
            // Operand registers hold their last value while idle.
            if (w_gnt_valid) begin
                r_iss_id <= w_gnt_id;
                r_iss_op <= w_sel_op;
                r_iss_a  <= w_sel_a;
                r_iss_b  <= w_sel_b;
                r_rr_ptr <= w_rr_next;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (r_rsp_valid[i] && rsp_ready_i[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                    r_busy[i]      <= 1'b0;
                end
                if (w_gnt_valid && (w_gnt_id == C_PTR_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end
                if (r_iss_valid && (r_iss_id == C_PTR_W'(i))) begin
                    r_rsp_valid[i]  <= 1'b1;
                    r_rsp_result[i] <= alu_result_i;
                    r_rsp_flag[i]   <= alu_flag_i;
                end
            end
        end
    end

    assign alu_op_o    = rstn_i ? r_iss_op : 5'd0;
    assign alu_a_o     = rstn_i ? r_iss_a  : 32'd0;
    assign alu_b_o     = rstn_i ? r_iss_b  : 32'd0;
    assign rsp_valid_o = r_rsp_valid & {NREQ{rstn_i}};
    assign rsp_flag_o  = r_rsp_flag  & {NREQ{rstn_i}};

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
            assign rsp_result_o[32*gi +: 32] = rstn_i ? r_rsp_result[gi] : 32'd0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arb
// Brief    : Self-checking bench for alu_share_arb (NREQ=2 and NREQ=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arb;

    localparam int N  = 2;
    localparam int N4 = 4;
    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_LTS = 5'd2, OP_LTU = 5'd3,
                           OP_XOR = 5'd4, OP_AND = 5'd5, OP_OR  = 5'd6, OP_SLL = 5'd7;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready, rsp_flag;
    logic [5*N-1:0]  req_op;
    logic [32*N-1:0] req_a, req_b, rsp_result;
    logic [4:0]      alu_op;
    logic [31:0]     alu_a, alu_b, alu_result;
    logic            alu_flag;

    logic [N4-1:0]    req_valid4, req_ready4, rsp_valid4, rsp_ready4, rsp_flag4;
    logic [5*N4-1:0]  req_op4;
    logic [32*N4-1:0] req_a4, req_b4, rsp_result4;
    logic [4:0]       alu_op4;
    logic [31:0]      alu_a4, alu_b4, alu_result4;
    logic             alu_flag4;

    int n_checks;
    int n_fail;

    // Reference ALU: returns {flag, result}.
    function automatic logic [32:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic lts, ltu;
        lts = $signed(a) < $signed(b);
        ltu = a < b;
        case (op)
            OP_ADD:  return {1'b0, a + b};
            OP_SUB:  return {1'b0, a - b};
            OP_LTS:  return {lts, 31'd0, lts};
            OP_LTU:  return {ltu, 31'd0, ltu};
            OP_XOR:  return {1'b0, a ^ b};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_SLL:  return {1'b0, a << b[4:0]};
            default: return 33'd0;
        endcase
    endfunction

    always_comb {alu_flag, alu_result}   = alu_fn(alu_op, alu_a, alu_b);
    always_comb {alu_flag4, alu_result4} = alu_fn(alu_op4, alu_a4, alu_b4);

    alu_share_arb #(.NREQ(N)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
        .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
        .alu_result_i(alu_result), .alu_flag_i(alu_flag),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_flag_o(rsp_flag)
    );

    alu_share_arb #(.NREQ(N4)) dut4 (
        .clk_i(clk), .rstn_i(rstn),
        .req_valid_i(req_valid4), .req_ready_o(req_ready4),
        .req_op_i(req_op4), .req_a_i(req_a4), .req_b_i(req_b4),
        .alu_op_o(alu_op4), .alu_a_o(alu_a4), .alu_b_o(alu_b4),
        .alu_result_i(alu_result4), .alu_flag_i(alu_flag4),
        .rsp_valid_o(rsp_valid4), .rsp_ready_i(rsp_ready4),
        .rsp_result_o(rsp_result4), .rsp_flag_o(rsp_flag4)
    );

    // Transaction-level model for the NREQ=2 instance.
    logic        m_out [N];
    int          m_at  [N];
    logic [32:0] m_res [N];
    int          m_rr;

    function automatic int exp_grant();
        int g;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && req_valid[(m_rr + k) % N] && !m_out[(m_rr + k) % N]) g = (m_rr + k) % N;
        end
        return g;
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]     = v;
        req_op[5*i +: 5] = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req_valid = '0; rsp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
        req_valid4 = '0; rsp_ready4 = '0; req_op4 = '0; req_a4 = '0; req_b4 = '0;
        next();
        next();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
        set_req(1, 1'b1, OP_SUB, 32'd9, 32'd3);
        rsp_ready = 2'b11;
        req_valid4 = 4'hF; rsp_ready4 = 4'hF;
        next();
        next();
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
        n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
        n_checks++; if (rsp_result !== 64'd0) begin n_fail++; $display("FAIL reset_rsp_result: got %h expected 0", rsp_result); end
        n_checks++; if (rsp_flag !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_flag: got %b expected 00", rsp_flag); end
        n_checks++; if ({alu_op, alu_a, alu_b} !== 69'd0) begin n_fail++; $display("FAIL reset_alu: got %h/%h/%h expected 0", alu_op, alu_a, alu_b); end
        n_checks++; if (req_ready4 !== 4'h0) begin n_fail++; $display("FAIL reset_ready4: got %b expected 0000", req_ready4); end
        next();
        rstn = 1'b1;
        req_valid = '0; req_valid4 = '0;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_after_rsp: got %b expected 00", rsp_valid); end
        n_checks++; if (rsp_valid4 !== 4'h0) begin n_fail++; $display("FAIL reset_after_rsp4: got %b expected 0000", rsp_valid4); end
        next();
    endtask

    task automatic test_single_op();
        do_reset();
        rsp_ready = 2'b11;
        set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7);
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_accept: got %b expected 01", req_ready); end
        next();
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_latency: got %b expected 00", rsp_valid); end
        n_checks++; if ({alu_op, alu_a, alu_b} !== {OP_ADD, 32'd5, 32'd7}) begin n_fail++; $display("FAIL single_alu_in: got %h/%h/%h expected 0/5/7", alu_op, alu_a, alu_b); end
        next();
        set_req(0, 1'b1, OP_SUB, 32'd50, 32'd8);
        @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected 01", rsp_valid); end
        n_checks++; if (rsp_result[31:0] !== 32'd12) begin n_fail++; $display("FAIL single_result: got %0d expected 12", rsp_result[31:0]); end
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL single_busy_block: got %b expected 00", req_ready); end
        next();
        @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_consumed: got %b expected 00", rsp_valid); end
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_reaccept: got %b expected 01", req_ready); end
        next();
        req_valid = '0;
    endtask

    task automatic test_fairness();
        logic [1:0] er, ev;
        do_reset();
        rsp_ready = 2'b11;
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
        set_req(1, 1'b1, OP_SUB, 32'd9, 32'd4);
        for (int c = 0; c < 12; c++) begin
            er = (c % 3 == 0) ? 2'b01 : (c % 3 == 1) ? 2'b10 : 2'b00;
            ev = (c >= 2 && c % 3 == 2) ? 2'b01 : (c >= 3 && c % 3 == 0) ? 2'b10 : 2'b00;
            @(negedge clk);
            n_checks++; if (req_ready !== er) begin n_fail++; $display("FAIL fair_grant c%0d: got %b expected %b", c, req_ready, er); end
            n_checks++; if (rsp_valid !== ev) begin n_fail++; $display("FAIL fair_rsp c%0d: got %b expected %b", c, rsp_valid, ev); end
            if (ev == 2'b01) begin
                n_checks++; if (rsp_result[31:0] !== 32'd3) begin n_fail++; $display("FAIL fair_res0 c%0d: got %0d expected 3", c, rsp_result[31:0]); end
            end
            if (ev == 2'b10) begin
                n_checks++; if (rsp_result[63:32] !== 32'd5) begin n_fail++; $display("FAIL fair_res1 c%0d: got %0d expected 5", c, rsp_result[63:32]); end
            end
            next();
        end
        req_valid = '0;
    endtask

    task automatic test_flag();
        do_reset();
        rsp_ready = 2'b11;
        set_req(1, 1'b1, OP_LTS, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL flag_lts_accept: got %b expected 10", req_ready); end
        next();
        req_valid = '0;
        next();
        @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL flag_lts_valid: got %b expected 10", rsp_valid); end
        n_checks++; if (rsp_flag[1] !== 1'b1) begin n_fail++; $display("FAIL flag_lts: got %b expected 1", rsp_flag[1]); end
        next();
        set_req(1, 1'b1, OP_LTU, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL flag_ltu_accept: got %b expected 10", req_ready); end
        next();
        req_valid = '0;
        next();
        @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL flag_ltu_valid: got %b expected 10", rsp_valid); end
        n_checks++; if (rsp_flag[1] !== 1'b0) begin n_fail++; $display("FAIL flag_ltu: got %b expected 0", rsp_flag[1]); end
        n_checks++; if (rsp_result[63:32] !== 32'd0) begin n_fail++; $display("FAIL flag_ltu_res: got %0d expected 0", rsp_result[63:32]); end
        next();
    endtask

    task automatic test_backpressure();
        logic [1:0] er;
        logic       ev0;
        do_reset();
        set_req(0, 1'b1, OP_SUB, 32'd10, 32'd3);
        set_req(1, 1'b1, OP_ADD, 32'd4, 32'd4);
        for (int c = 0; c < 14; c++) begin
            rsp_ready = {1'b1, (c >= 12)};
            er  = (c == 0 || c == 13) ? 2'b01 : (c % 3 == 1) ? 2'b10 : 2'b00;
            ev0 = (c >= 2 && c <= 12);
            @(negedge clk);
            n_checks++; if (req_ready !== er) begin n_fail++; $display("FAIL bp_grant c%0d: got %b expected %b", c, req_ready, er); end
            n_checks++; if (rsp_valid[0] !== ev0) begin n_fail++; $display("FAIL bp_hold c%0d: got %b expected %b", c, rsp_valid[0], ev0); end
            if (ev0) begin
                n_checks++; if (rsp_result[31:0] !== 32'd7) begin n_fail++; $display("FAIL bp_result c%0d: got %0d expected 7", c, rsp_result[31:0]); end
            end
            next();
            if (c == 0) set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp_ready = 2'b00;
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rmid_acc0: got %b expected 01", req_ready); end
        next();
        req_valid = '0;
        set_req(1, 1'b1, OP_ADD, 32'd3, 32'd4);
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rmid_acc1: got %b expected 10", req_ready); end
        next();
        req_valid = '0;
        rstn = 1'b0;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rmid_in_reset_valid: got %b expected 00", rsp_valid); end
        n_checks++; if (rsp_result !== 64'd0) begin n_fail++; $display("FAIL rmid_in_reset_result: got %h expected 0", rsp_result); end
        n_checks++; if (alu_a !== 32'd0) begin n_fail++; $display("FAIL rmid_in_reset_alu: got %h expected 0", alu_a); end
        next();
        rstn = 1'b1;
        set_req(0, 1'b1, OP_ADD, 32'd20, 32'd22);
        set_req(1, 1'b1, OP_ADD, 32'd5, 32'd5);
        @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rmid_stale_a: got %b expected 00", rsp_valid); end
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rmid_rr_zero: got %b expected 01", req_ready); end
        next();
        @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rmid_stale_b: got %b expected 00", rsp_valid); end
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rmid_busy_clear: got %b expected 10", req_ready); end
        next();
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL rmid_new0: got %b expected 01", rsp_valid); end
        n_checks++; if (rsp_result[31:0] !== 32'd42) begin n_fail++; $display("FAIL rmid_res0: got %0d expected 42", rsp_result[31:0]); end
        next();
        @(negedge clk);
        n_checks++; if (rsp_valid !== 2'b11) begin n_fail++; $display("FAIL rmid_new1: got %b expected 11", rsp_valid); end
        n_checks++; if (rsp_result[63:32] !== 32'd10) begin n_fail++; $display("FAIL rmid_res1: got %0d expected 10", rsp_result[63:32]); end
        next();
    endtask

    task automatic test_wrap4();
        logic [3:0] er, ev;
        do_reset();
        rsp_ready4 = 4'hF;
        req_valid4 = 4'b1010;
        req_op4[5 +: 5]  = OP_ADD; req_a4[32 +: 32] = 32'd100;     req_b4[32 +: 32] = 32'd1;
        req_op4[15 +: 5] = OP_XOR; req_a4[96 +: 32] = 32'h0000_F0F0; req_b4[96 +: 32] = 32'h0000_0FF0;
        for (int c = 0; c < 12; c++) begin
            er = (c % 3 == 0) ? 4'b0010 : (c % 3 == 1) ? 4'b1000 : 4'b0000;
            ev = (c >= 2 && c % 3 == 2) ? 4'b0010 : (c >= 3 && c % 3 == 0) ? 4'b1000 : 4'b0000;
            @(negedge clk);
            n_checks++; if (req_ready4 !== er) begin n_fail++; $display("FAIL wrap_grant c%0d: got %b expected %b", c, req_ready4, er); end
            n_checks++; if (rsp_valid4 !== ev) begin n_fail++; $display("FAIL wrap_rsp c%0d: got %b expected %b", c, rsp_valid4, ev); end
            if (ev == 4'b0010) begin
                n_checks++; if (rsp_result4[63:32] !== 32'd101) begin n_fail++; $display("FAIL wrap_res1 c%0d: got %0d expected 101", c, rsp_result4[63:32]); end
            end
            if (ev == 4'b1000) begin
                n_checks++; if (rsp_result4[127:96] !== 32'h0000_FF00) begin n_fail++; $display("FAIL wrap_res3 c%0d: got %h expected 0000ff00", c, rsp_result4[127:96]); end
            end
            next();
        end
        // Last grant went to 3, so the pointer has wrapped to 0 and 0 beats 1.
        req_valid4 = 4'b1011;
        @(negedge clk);
        n_checks++; if (req_ready4 !== 4'b0001) begin n_fail++; $display("FAIL wrap_ptr_zero: got %b expected 0001", req_ready4); end
        next();
        req_valid4 = '0;
    endtask

    task automatic test_random();
        int         g;
        logic [1:0] er;
        logic       ev;
        logic [4:0] l_op;
        logic [31:0] l_a, l_b;
        logic       have_last;
        do_reset();
        for (int i = 0; i < N; i++) m_out[i] = 1'b0;
        m_rr = 0;
        have_last = 1'b0;
        l_op = '0; l_a = '0; l_b = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                set_req(i, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom(), $urandom());
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            g  = exp_grant();
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            n_checks++; if (req_ready !== er) begin n_fail++; $display("FAIL rnd_grant c%0d: got %b expected %b", c, req_ready, er); end
            for (int i = 0; i < N; i++) begin
                ev = m_out[i] && (c >= m_at[i]);
                n_checks++; if (rsp_valid[i] !== ev) begin n_fail++; $display("FAIL rnd_valid%0d c%0d: got %b expected %b", i, c, rsp_valid[i], ev); end
                if (ev) begin
                    n_checks++;
                    if ({rsp_flag[i], rsp_result[32*i +: 32]} !== m_res[i]) begin
                        n_fail++; $display("FAIL rnd_data%0d c%0d: got %h expected %h", i, c, {rsp_flag[i], rsp_result[32*i +: 32]}, m_res[i]);
                    end
                end
            end
            if (have_last) begin
                n_checks++;
                if ({alu_op, alu_a, alu_b} !== {l_op, l_a, l_b}) begin
                    n_fail++; $display("FAIL rnd_alu c%0d: got %h/%h/%h expected %h/%h/%h", c, alu_op, alu_a, alu_b, l_op, l_a, l_b);
                end
            end
            @(posedge clk);
            for (int i = 0; i < N; i++) begin
                if (m_out[i] && (c >= m_at[i]) && rsp_ready[i]) m_out[i] = 1'b0;
            end
            if (g >= 0) begin
                l_op = req_op[5*g +: 5]; l_a = req_a[32*g +: 32]; l_b = req_b[32*g +: 32];
                m_out[g] = 1'b1;
                m_at[g]  = c + 2;
                m_res[g] = alu_fn(l_op, l_a, l_b);
                m_rr     = (g + 1) % N;
                have_last = 1'b1;
            end
            #1;
        end
        req_valid = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_op();
        test_fairness();
        test_flag();
        test_backpressure();
        test_reset_mid();
        test_wrap4();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
